// File: rtl/soc_bus_arb.sv
// soc_bus_arb: round-robin N-master to N-slave bus fabric with one outstanding transaction.
// Define SOC_BUS_TIMEOUT_EN to compile in the slave timeout abort.
module soc_bus_arb #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_MASTERS-1:0]      m_req,
    input  logic [N_MASTERS-1:0]      m_we,
    input  logic [4*N_MASTERS-1:0]    m_be,
    input  logic [32*N_MASTERS-1:0]   m_addr,
    input  logic [32*N_MASTERS-1:0]   m_wdata,
    output logic [31:0]               m_rdata,
    output logic [N_MASTERS-1:0]      m_ack,
    output logic [N_MASTERS-1:0]      m_error,
    input  logic [32*N_SLAVES-1:0]    s_base,
    input  logic [32*N_SLAVES-1:0]    s_size,
    output logic [N_SLAVES-1:0]       s_req,
    output logic                      s_we,
    output logic [3:0]                s_be,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    input  logic [32*N_SLAVES-1:0]    s_rdata,
    input  logic [N_SLAVES-1:0]       s_ack,
    input  logic [N_SLAVES-1:0]       s_error
);
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [MW-1:0]        r_ptr;
    logic [SW-1:0]        r_sel;
    logic [N_SLAVES-1:0]  r_sreq;
    logic                 r_we;
    logic [3:0]           r_be;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_err;

    logic [MW-1:0]        w_gnt;
    logic                 w_anyReq;
    logic [31:0]          w_addr;
    logic                 w_hit;
    logic [SW-1:0]        w_hitIdx;
    logic                 w_sack;
    logic                 w_timeout;
    logic [N_MASTERS-1:0] w_ackVec;

    // Descending scan so the nearest requester above the pointer is the last one assigned.
    always_comb begin
        int idx;
        w_gnt    = r_ptr;
        w_anyReq = 1'b0;
        idx      = 0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            idx = (int'(r_ptr) + k) % N_MASTERS;
            if (m_req[idx]) begin
                w_gnt    = MW'(idx);
                w_anyReq = 1'b1;
            end
        end
    end

    assign w_addr = m_addr[w_gnt*32 +: 32];

    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((s_size[i*32 +: 32] != 32'd0) && (w_addr >= s_base[i*32 +: 32]) &&
                ((w_addr - s_base[i*32 +: 32]) < s_size[i*32 +: 32])) begin
                w_hit    = 1'b1;
                w_hitIdx = SW'(i);
            end
        end
    end

    assign w_sack = s_ack[r_sel];

`ifdef SOC_BUS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (r_state != BUSY) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds completed BUSY cycles, so this cycle is the TIMEOUT-th one.
    assign w_timeout = (r_state == BUSY) && !w_sack && (r_cnt == CW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_next = w_hit ? BUSY : RESP;
            BUSY:    if (w_sack || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr   <= MW'(N_MASTERS - 1);
            r_sel   <= '0;
            r_sreq  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_ptr   <= w_gnt;
                        r_we    <= m_we[w_gnt];
                        r_be    <= m_be[w_gnt*4 +: 4];
                        r_addr  <= w_addr;
                        r_wdata <= m_wdata[w_gnt*32 +: 32];
                        if (w_hit) begin
                            r_sel            <= w_hitIdx;
                            r_sreq           <= '0;
                            r_sreq[w_hitIdx] <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (w_sack) begin
                        r_sreq  <= '0;
                        r_rdata <= s_rdata[r_sel*32 +: 32];
                        r_err   <= s_error[r_sel];
                    end else if (w_timeout) begin
                        r_sreq  <= '0;
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_ackVec = '0;
        if (r_state == RESP) begin
            w_ackVec[r_ptr] = 1'b1;
        end
    end

    assign m_ack   = w_ackVec;
    assign m_error = r_err ? w_ackVec : '0;
    assign m_rdata = r_rdata;
    assign s_req   = r_sreq;
    assign s_we    = r_we;
    assign s_be    = r_be;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;

endmodule

// File: tb/tb_soc_bus_arb.sv
// tb_soc_bus_arb: directed and randomized checks of soc_bus_arb against a transaction-level model.
// Build with SOC_BUS_TIMEOUT_EN to exercise the timeout abort (TIMEOUT=8).
module tb_soc_bus_arb;
    localparam int NM = 2;
    localparam int NS = 4;
`ifdef SOC_BUS_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic          clk;
    logic          rstn;
    logic [1:0]    m_req, m_we;
    logic [7:0]    m_be;
    logic [63:0]   m_addr, m_wdata;
    logic [31:0]   m_rdata;
    logic [1:0]    m_ack, m_error;
    logic [127:0]  s_base, s_size;
    logic [3:0]    s_req;
    logic          s_we;
    logic [3:0]    s_be;
    logic [31:0]   s_addr, s_wdata;
    logic [127:0]  s_rdata;
    logic [3:0]    s_ack, s_error;

    logic [31:0]   slaveData [NS];
    logic          slaveErr  [NS];
    int            waitCycles;
    logic          stall;
    logic [3:0]    spurious;
    int            busyCnt;
    int            vecCount, missCount, lastGrant;

    soc_bus_arb #(.N_MASTERS(NM), .N_SLAVES(NS), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_error(m_error),
        .s_base(s_base), .s_size(s_size),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .s_error(s_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: acknowledges once the request has been held for waitCycles cycles.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) busyCnt <= 0;
        else if (s_req != 4'b0) busyCnt <= busyCnt + 1;
        else busyCnt <= 0;
    end

    always_comb begin
        s_ack = spurious;
        if (!stall && busyCnt >= waitCycles) s_ack = s_ack | s_req;
    end

    always_comb begin
        s_rdata = '0;
        s_error = '0;
        for (int i = 0; i < NS; i++) begin
            s_rdata[i*32 +: 32] = slaveData[i];
            s_error[i]          = slaveErr[i];
        end
    end

    function automatic int decodeRef(input logic [31:0] addr);
        longint a, b, z;
        a = longint'(addr);
        for (int i = 0; i < NS; i++) begin
            b = longint'(s_base[i*32 +: 32]);
            z = longint'(s_size[i*32 +: 32]);
            if (z != 0 && a >= b && a < b + z) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        m_we[m]             = we;
        m_be[m*4 +: 4]      = be;
        m_addr[m*32 +: 32]  = addr;
        m_wdata[m*32 +: 32] = wdata;
        m_req[m]            = 1'b1;
    endtask

    task automatic runTxn(input int m, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int          expSlave, n, reqCycle, expLat;
        logic [3:0]  reqObs, beObs;
        logic        weObs, expErr;
        logic [31:0] addrObs, wdataObs, expRdata;
        expSlave = decodeRef(addr);
        reqCycle = 0; reqObs = '0; beObs = '0; weObs = 1'b0; addrObs = '0; wdataObs = '0;
        if (expSlave < 0) begin
            expLat = 1; expRdata = '0; expErr = 1'b1;
        end else begin
            expLat = 2 + waitCycles; expRdata = slaveData[expSlave]; expErr = slaveErr[expSlave];
        end
        applyStimulus(m, we, be, addr, wdata);
        n = 0;
        do begin
            @(posedge clk); @(negedge clk); n++;
            if (reqCycle == 0 && s_req != 4'b0) begin
                reqCycle = n; reqObs = s_req; weObs = s_we; beObs = s_be;
                addrObs = s_addr; wdataObs = s_wdata;
            end
        end while (m_ack == 2'b0 && n < 50);
        m_req[m]  = 1'b0;
        lastGrant = m;
        checkOutput("ack_latency", 32'(n), 32'(expLat));
        if (m_ack == 2'b0) return;
        checkOutput("ack_vector", 32'(m_ack), 32'(1 << m));
        checkOutput("error_vector", 32'(m_error), expErr ? 32'(1 << m) : 32'd0);
        checkOutput("rdata", m_rdata, expRdata);
        checkOutput("sreq_onehot", 32'(reqObs), (expSlave < 0) ? 32'd0 : 32'(1 << expSlave));
        if (expSlave >= 0) begin
            checkOutput("sreq_cycle", 32'(reqCycle), 32'd1);
            checkOutput("s_we", 32'(weObs), 32'(we));
            checkOutput("s_be", 32'(beObs), 32'(be));
            checkOutput("s_addr", addrObs, addr);
            checkOutput("s_wdata", wdataObs, wdata);
        end
        @(posedge clk); @(negedge clk);
        checkOutput("ack_pulse", 32'(m_ack), 32'd0);
        checkOutput("sreq_released", 32'(s_req), 32'd0);
    endtask

    // Both masters request continuously; grants must alternate, one every 3 cycles.
    task automatic runRoundRobin(input int nAcks);
        int n, acks, prevAck, expG;
        waitCycles = 0;
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        applyStimulus(1, 1'b1, 4'hF, 32'h0000_0200, 32'hA5A5_0001);
        n = 0; acks = 0; prevAck = 0;
        while (acks < nAcks && n < 60) begin
            @(posedge clk); @(negedge clk); n++;
            if (acks > 0 && n == prevAck + 1) checkOutput("rr_pulse", 32'(m_ack), 32'd0);
            if (m_ack != 2'b0) begin
                expG = (lastGrant + 1) % NM;
                checkOutput("rr_grant", 32'(m_ack), 32'(1 << expG));
                if (acks > 0) checkOutput("rr_spacing", 32'(n - prevAck), 32'd3);
                else checkOutput("rr_first_latency", 32'(n), 32'd2);
                prevAck = n; lastGrant = expG; acks++;
                if (acks == nAcks) m_req = 2'b00;
            end
        end
        m_req = 2'b00;
        checkOutput("rr_count", 32'(acks), 32'(nAcks));
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        int n, ackSeen, region;
        logic [31:0] addr;
        vecCount = 0; missCount = 0; lastGrant = NM - 1;
        rstn = 1'b0; m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
        stall = 1'b0; spurious = '0; waitCycles = 0;
        s_base = {32'h0, 32'h0002_0000, 32'h0001_0000, 32'h0};
        s_size = {32'h0, 32'h0000_0100, 32'h0000_0100, 32'h0001_0000};
        for (int i = 0; i < NS; i++) begin
            slaveData[i] = 32'h1000_0000 + 32'(i); slaveErr[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("rst_sreq", 32'(s_req), 32'd0);
        checkOutput("rst_mack", 32'(m_ack), 32'd0);
        checkOutput("rst_merror", 32'(m_error), 32'd0);
        checkOutput("rst_rdata", m_rdata, 32'd0);
        checkOutput("rst_saddr", s_addr, 32'd0);
        checkOutput("rst_swdata", s_wdata, 32'd0);
        checkOutput("rst_sbe", 32'(s_be), 32'd0);
        checkOutput("rst_swe", 32'(s_we), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        slaveData[1] = 32'hDEAD_BEEF; waitCycles = 0;
        runTxn(0, 1'b0, 4'hF, 32'h0001_0004, 32'h0);
        slaveData[0] = 32'h0BAD_F00D; waitCycles = 1;
        runTxn(1, 1'b1, 4'b0011, 32'h0000_0FF0, 32'h1234_5678);
        runTxn(0, 1'b0, 4'hF, 32'h0003_0000, 32'h0);

        waitCycles = 0; slaveErr[2] = 1'b1;
        runTxn(0, 1'b0, 4'hF, 32'h0000_FFFF, 32'h0);
        runTxn(1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
        runTxn(0, 1'b1, 4'h1, 32'h0001_00FF, 32'h5555_AAAA);
        runTxn(1, 1'b0, 4'hF, 32'h0001_0100, 32'h0);
        runTxn(0, 1'b0, 4'hF, 32'h0002_00FF, 32'h0);
        runTxn(1, 1'b0, 4'hF, 32'h0002_0100, 32'h0);
        slaveErr[2] = 1'b0;

        s_base[3*32 +: 32] = 32'h0001_0000; s_size[3*32 +: 32] = 32'h40;
        slaveData[3] = 32'h3333_3333;
        runTxn(0, 1'b0, 4'hF, 32'h0001_0020, 32'h0);
        s_size[3*32 +: 32] = 32'h0;

        runRoundRobin(4);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NS; i++) begin
                slaveData[i] = $urandom; slaveErr[i] = 1'($urandom_range(0, 1));
            end
            waitCycles = int'($urandom_range(0, 3));
            region = int'($urandom_range(0, 3));
            case (region)
                0:       addr = $urandom_range(0, 32'hFFFF);
                1:       addr = 32'h0001_0000 + $urandom_range(0, 255);
                2:       addr = 32'h0002_0000 + $urandom_range(0, 255);
                default: addr = 32'h0002_0100 + $urandom_range(0, 32'h7FFF_FFFF);
            endcase
            runTxn(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), addr, $urandom);
        end

        stall = 1'b1; spurious = 4'b1011;
        applyStimulus(1, 1'b0, 4'hF, 32'h0002_0010, 32'h0);
`ifdef SOC_BUS_TIMEOUT_EN
        n = 0;
        do begin
            @(posedge clk); @(negedge clk); n++;
        end while (m_ack == 2'b0 && n < 40);
        m_req = 2'b00; lastGrant = 1;
        checkOutput("tmo_latency", 32'(n), 32'(TMO + 1));
        checkOutput("tmo_ack", 32'(m_ack), 32'b10);
        checkOutput("tmo_error", 32'(m_error), 32'b10);
        checkOutput("tmo_rdata", m_rdata, 32'd0);
        @(posedge clk); @(negedge clk);
        checkOutput("tmo_sreq_dropped", 32'(s_req), 32'd0);
        applyStimulus(1, 1'b0, 4'hF, 32'h0002_0010, 32'h0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
`else
        ackSeen = 0;
        repeat (100) begin
            @(posedge clk); @(negedge clk);
            if (m_ack != 2'b0) ackSeen++;
        end
        checkOutput("stall_noack", 32'(ackSeen), 32'd0);
`endif
        checkOutput("stall_sreq", 32'(s_req), 32'b0100);

        #2 rstn = 1'b0;
        #1;
        checkOutput("midrst_sreq", 32'(s_req), 32'd0);
        checkOutput("midrst_mack", 32'(m_ack), 32'd0);
        checkOutput("midrst_merror", 32'(m_error), 32'd0);
        checkOutput("midrst_rdata", m_rdata, 32'd0);
        m_req = 2'b00; stall = 1'b0; spurious = '0;
        @(negedge clk);
        rstn = 1'b1; lastGrant = NM - 1;
        runRoundRobin(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
